dino_jump_ctrl: RTL and testbench

//  Sequences the dino's vertical motion: turns jump/duck presses into a tick-stepped

---
 rtl/dino_pkg.sv | 24 ++
 rtl/dino_jump_ctrl_if.sv | 27 ++
 rtl/dino_edge_pend.sv | 31 +++
 rtl/dino_jump_ctrl.sv | 147 ++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// Shared dino definitions: motion state enum and default geometry/physics constants
// reused by the jump controller, collision logic and renderer.
package dino_pkg;

   typedef enum logic [2:0] {
      GROUND = 3'd0,
      DUCK   = 3'd1,
      RISE   = 3'd2,
      FALL   = 3'd3,
      DEAD   = 3'd4
   } dino_state_e;

   localparam int DINO_Y_W       = 10;
   localparam int DINO_GROUND_Y  = 200;
   localparam int DINO_JUMP_V0   = 12;
   localparam int DINO_GRAVITY   = 1;
   localparam int DINO_MAX_FALL  = 12;
   localparam int DINO_BUF_TICKS = 4;

   function automatic logic is_airborne(dino_state_e s);
      return (s == RISE) || (s == FALL);
   endfunction

endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Control/status bundle between the game logic (master) and the dino jump controller (slave).
interface dino_jump_ctrl_if
   import dino_pkg::*;
#(
   parameter int Y_W = DINO_Y_W
);
   logic           tick;
   logic           jump_btn;
   logic           duck_btn;
   logic           is_dead;
   logic           is_paused;
   logic           restart;
   logic [Y_W-1:0] dino_y;
   logic           airborne;
   logic           on_ground;
   logic           ducking;

   modport master (
      output tick, jump_btn, duck_btn, is_dead, is_paused, restart,
      input  dino_y, airborne, on_ground, ducking
   );

   modport slave (
      input  tick, jump_btn, duck_btn, is_dead, is_paused, restart,
      output dino_y, airborne, on_ground, ducking
   );
endinterface

// File: rtl/dino_edge_pend.sv
// Rising-edge detector with a pending latch: an edge is usable in the clk it occurs
// and is remembered until consumed or dropped.
module dino_edge_pend (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic consume,
   input  logic drop,
   output logic pend
);
   logic btn_q, btn_d;
   logic pend_q, pend_d;
   logic edge_w;

   always_comb begin
      btn_d  = btn;
      edge_w = btn & ~btn_q;
      pend   = pend_q | edge_w;
      pend_d = (consume | drop) ? 1'b0 : pend;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         btn_q  <= btn_d;
         pend_q <= pend_d;
      end
   end
endmodule

// File: rtl/dino_jump_ctrl.sv
// Dino vertical-motion sequencer: tick-stepped jump trajectory and ground/air/duck flags.
// Optional DINO_JUMP_BUFFER_EN keeps a jump pressed just before landing for the next tick.
module dino_jump_ctrl
   import dino_pkg::*;
#(
   parameter int Y_W      = DINO_Y_W,
   parameter int GROUND_Y = DINO_GROUND_Y,
   parameter int JUMP_V0  = DINO_JUMP_V0,
   parameter int GRAVITY  = DINO_GRAVITY,
   parameter int MAX_FALL = DINO_MAX_FALL
`ifdef DINO_JUMP_BUFFER_EN
  ,parameter int BUF_TICKS = DINO_BUF_TICKS
`endif
) (
   input logic             clk,
   input logic             rst,
   dino_jump_ctrl_if.slave bus
);
   localparam logic [Y_W-1:0] GROUND_V = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0] V0_V     = Y_W'(JUMP_V0);
   localparam logic [Y_W-1:0] GRAV_V   = Y_W'(GRAVITY);
   localparam logic [Y_W-1:0] MAXF_V   = Y_W'(MAX_FALL);

   dino_state_e    state_q, state_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [Y_W-1:0] vel_q, vel_d;
   logic           airborne_q, airborne_d;
   logic           on_ground_q, on_ground_d;
   logic           ducking_q, ducking_d;

   logic           jump_pend;
   logic           consume;
   logic           drop;

   logic [Y_W-1:0] launch_y, rise_y, vel_dec, vel_inc, vel_fall;
   logic [Y_W:0]   fall_sum;
   logic           rise_done;
   logic           land;

   dino_edge_pend u_jump_pend (
      .clk     (clk),
      .rst     (rst),
      .btn     (bus.jump_btn),
      .consume (consume),
      .drop    (drop),
      .pend    (jump_pend)
   );

   // Upward moves saturate at row 0; downward moves clamp onto the ground row.
   assign launch_y  = (y_q > V0_V)  ? (y_q - V0_V)  : '0;
   assign rise_y    = (y_q > vel_q) ? (y_q - vel_q) : '0;
   assign vel_dec   = vel_q - GRAV_V;
   assign rise_done = ({1'b0, vel_q} <= ({1'b0, GRAV_V} + {1'b0, GRAV_V}));
   assign vel_inc   = vel_q + GRAV_V;
   assign vel_fall  = (vel_inc > MAXF_V) ? MAXF_V : vel_inc;
   assign fall_sum  = {1'b0, y_q} + {1'b0, vel_fall};
   assign land      = (fall_sum >= {1'b0, GROUND_V});

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      vel_d   = vel_q;
      consume = 1'b0;

      if ((state_q == DEAD) && bus.restart) begin
         state_d = GROUND;
         y_d     = GROUND_V;
         vel_d   = '0;
      end else if (bus.tick && !bus.is_paused) begin
         if (bus.is_dead) begin
            state_d = DEAD;
         end else begin
            unique case (state_q)
               GROUND, DUCK: begin
                  if (jump_pend) begin
                     consume = 1'b1;
                     state_d = RISE;
                     vel_d   = V0_V;
                     y_d     = launch_y;
                  end else if ((state_q == GROUND) && bus.duck_btn) begin
                     state_d = DUCK;
                  end else if ((state_q == DUCK) && !bus.duck_btn) begin
                     state_d = GROUND;
                  end
               end
               RISE: begin
                  y_d = rise_y;
                  if (rise_done) begin
                     state_d = FALL;
                     vel_d   = '0;
                  end else begin
                     vel_d = vel_dec;
                  end
               end
               FALL: begin
                  vel_d = vel_fall;
                  if (land) begin
                     y_d     = GROUND_V;
                     state_d = bus.duck_btn ? DUCK : GROUND;
                  end else begin
                     y_d = fall_sum[Y_W-1:0];
                  end
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end
      end

      // Jump edges are only worth keeping where a later tick can launch them.
`ifdef DINO_JUMP_BUFFER_EN
      drop = bus.is_paused || (state_q == RISE) || (state_q == DEAD) ||
             ((state_q == FALL) &&
              ((32'(y_q) + 32'(BUF_TICKS * MAX_FALL)) < 32'(GROUND_Y)));
`else
      drop = bus.is_paused || (state_q == RISE) || (state_q == FALL) || (state_q == DEAD);
`endif

      airborne_d  = is_airborne(state_d);
      on_ground_d = (state_d == GROUND) || (state_d == DUCK);
      ducking_d   = (state_d == DUCK);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= GROUND;
         y_q         <= GROUND_V;
         vel_q       <= '0;
         airborne_q  <= 1'b0;
         on_ground_q <= 1'b1;
         ducking_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         vel_q       <= vel_d;
         airborne_q  <= airborne_d;
         on_ground_q <= on_ground_d;
         ducking_q   <= ducking_d;
      end
   end

   assign bus.dino_y    = y_q;
   assign bus.airborne  = airborne_q;
   assign bus.on_ground = on_ground_q;
   assign bus.ducking   = ducking_q;
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: directed scenarios then random stimulus, every clk compared
// against a behavioural trajectory model.
module tb_dino_jump_ctrl;
   localparam int G_Y  = 200;
   localparam int V0   = 12;
   localparam int GRV  = 1;
   localparam int MAXF = 12;
   localparam int BUFT = 4;

   typedef enum {M_GND, M_DUCK, M_UP, M_DOWN, M_DEAD} mmode_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dino_jump_ctrl_if #(.Y_W(10)) bus ();

   dino_jump_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   mmode_t m_st;
   int     m_y, m_v, m_min;
   bit     m_pend, m_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = M_GND; m_y = G_Y; m_v = 0; m_pend = 0; m_prev = 0;
   endtask

   // One clk of the reference behaviour, from the inputs currently applied.
   task automatic model_clk();
      bit     edge_now, avail, used, keep;
      mmode_t st0;
      int     y0;
      st0 = m_st; y0 = m_y; used = 0;
      edge_now = bus.jump_btn && !m_prev;
      m_prev   = bus.jump_btn;
      avail    = m_pend || edge_now;
      if (m_st == M_DEAD && bus.restart) begin
         m_st = M_GND; m_y = G_Y; m_v = 0;
      end else if (bus.tick && !bus.is_paused) begin
         if (bus.is_dead) m_st = M_DEAD;
         else if (m_st == M_GND || m_st == M_DUCK) begin
            if (avail) begin
               used = 1; m_st = M_UP; m_v = V0; m_y = (m_y > V0) ? m_y - V0 : 0;
            end else if (m_st == M_GND && bus.duck_btn) m_st = M_DUCK;
            else if (m_st == M_DUCK && !bus.duck_btn) m_st = M_GND;
         end else if (m_st == M_UP) begin
            m_y = (m_y > m_v) ? m_y - m_v : 0;
            m_v = m_v - GRV;
            if (m_v <= GRV) begin m_st = M_DOWN; m_v = 0; end
         end else if (m_st == M_DOWN) begin
            m_v = (m_v + GRV > MAXF) ? MAXF : m_v + GRV;
            if (m_y + m_v >= G_Y) begin
               m_y = G_Y; m_st = bus.duck_btn ? M_DUCK : M_GND;
            end else m_y = m_y + m_v;
         end
      end
      if (bus.is_paused || used || st0 == M_UP || st0 == M_DEAD) keep = 0;
`ifdef DINO_JUMP_BUFFER_EN
      else if (st0 == M_DOWN) keep = avail && (y0 + BUFT * MAXF >= G_Y);
`else
      else if (st0 == M_DOWN) keep = 0;
`endif
      else keep = avail;
      m_pend = keep;
      if (m_y < m_min) m_min = m_y;
   endtask

   task automatic cmp_model();
      chk("y", bus.dino_y, m_y);
      chk("airborne", bus.airborne, (m_st == M_UP || m_st == M_DOWN));
      chk("on_ground", bus.on_ground, (m_st == M_GND || m_st == M_DUCK));
      chk("ducking", bus.ducking, (m_st == M_DUCK));
   endtask

   task automatic cyc();
      model_clk();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         bus.tick = 1'b1; cyc();
         bus.tick = 1'b0; cyc();
      end
   endtask

   task automatic land_bounded(input string tag);
      int k;
      k = 0;
      while (m_st != M_GND && m_st != M_DUCK && k < 100) begin tick_n(1); k++; end
      chk(tag, (k < 100), 1);
   endtask

   initial begin
      int n, min_y, ticks_to_land;
      bus.tick = 0; bus.jump_btn = 0; bus.duck_btn = 0;
      bus.is_dead = 0; bus.is_paused = 0; bus.restart = 0;

      // Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      cmp_model();
      chk("rst_y", bus.dino_y, 200);
      chk("rst_on_ground", bus.on_ground, 1);
      rst = 1'b1;
      cyc();
      $display("step: reset y=%0d", bus.dino_y);

      // Full jump from ground; edge waits for the tick
      bus.jump_btn = 1; cyc();
      chk("pend_wait_y", bus.dino_y, 200);
      tick_n(1);
      chk("launch_y", bus.dino_y, 188);
      chk("launch_air", bus.airborne, 1);
      tick_n(1);
      chk("rise2_y", bus.dino_y, 176);
      m_min = 1000; min_y = 1000; n = 2;
      while (m_st != M_GND && n < 200) begin
         tick_n(1); n++;
         if (int'(bus.dino_y) < min_y) min_y = int'(bus.dino_y);
      end
      chk("land_bound", (n < 200), 1);
      chk("apex", min_y, m_min);
      chk("land_y", bus.dino_y, 200);
      chk("land_on_ground", bus.on_ground, 1);
      ticks_to_land = n;
      $display("step: jump landed after %0d ticks apex %0d", n, min_y);

      // Reset while falling
      bus.jump_btn = 0; cyc(); bus.jump_btn = 1; tick_n(1); bus.jump_btn = 0;
      n = 0;
      while (!(m_st == M_DOWN && m_y >= 150) && n < 100) begin tick_n(1); n++; end
      chk("fall_reach", (n < 100), 1);
      rst = 1'b0; #1; model_reset();
      chk("rstf_y", bus.dino_y, 200);
      chk("rstf_on_ground", bus.on_ground, 1);
      chk("rstf_airborne", bus.airborne, 0);
      @(posedge clk); #1; rst = 1'b1;
      cmp_model();
      $display("step: reset mid-fall y=%0d", bus.dino_y);

      // Duck, then jump out of duck
      bus.duck_btn = 1; tick_n(1);
      chk("duck_flag", bus.ducking, 1);
      chk("duck_on_ground", bus.on_ground, 1);
      bus.jump_btn = 1; tick_n(1);
      chk("duckjump_air", bus.airborne, 1);
      chk("duckjump_duck", bus.ducking, 0);
      chk("duckjump_y", bus.dino_y, 188);
      bus.duck_btn = 0; bus.jump_btn = 0;
      land_bounded("duckjump_land");
      $display("step: duck jump y=%0d", bus.dino_y);

      // Death mid-rise freezes, restart returns to ground
      bus.jump_btn = 1; tick_n(2); bus.jump_btn = 0;
      bus.is_dead = 1; tick_n(1);
      chk("dead_air", bus.airborne, 0);
      tick_n(20);
      chk("dead_y", bus.dino_y, 176);
      chk("dead_on_ground", bus.on_ground, 0);
      bus.is_dead = 0; bus.restart = 1; cyc(); bus.restart = 0;
      chk("restart_y", bus.dino_y, 200);
      chk("restart_on_ground", bus.on_ground, 1);
      $display("step: dead/restart y=%0d", bus.dino_y);

      // Pause mid-rise, with a jump edge that must be dropped
      bus.jump_btn = 1; tick_n(3); bus.jump_btn = 0;
      bus.is_paused = 1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) bus.jump_btn = 1;
         if (i == 7) bus.jump_btn = 0;
         tick_n(1);
      end
      chk("pause_y", bus.dino_y, 165);
      chk("pause_air", bus.airborne, 1);
      bus.is_paused = 0;
      land_bounded("pause_land");
      tick_n(3);
      chk("pause_drop_y", bus.dino_y, 200);
      chk("pause_drop_air", bus.airborne, 0);
      $display("step: pause y=%0d", bus.dino_y);

      // Jump edge two ticks before landing
      bus.jump_btn = 1; tick_n(1); bus.jump_btn = 0;
      tick_n(ticks_to_land - 3);
      bus.jump_btn = 1; cyc();
      tick_n(2);
      chk("buf_land_y", bus.dino_y, 200);
      chk("buf_land_gnd", bus.on_ground, 1);
      tick_n(1);
`ifdef DINO_JUMP_BUFFER_EN
      chk("buf_relaunch_y", bus.dino_y, 188);
      chk("buf_relaunch_air", bus.airborne, 1);
`else
      chk("nobuf_stay_y", bus.dino_y, 200);
      chk("nobuf_stay_gnd", bus.on_ground, 1);
`endif
      bus.jump_btn = 0;
      land_bounded("buf_final_land");
      $display("step: late jump edge y=%0d", bus.dino_y);

      // Random stimulus
      for (int i = 0; i < 3000; i++) begin
         bus.tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0)   bus.jump_btn  = ~bus.jump_btn;
         if ($urandom_range(0, 15) == 0)  bus.duck_btn  = ~bus.duck_btn;
         if ($urandom_range(0, 39) == 0)  bus.is_paused = ~bus.is_paused;
         if ($urandom_range(0, 149) == 0) bus.is_dead   = ~bus.is_dead;
         bus.restart = ($urandom_range(0, 30) == 0);
         cyc();
      end
      bus.tick = 0; bus.restart = 0;
      $display("step: random phase done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
